// File: rtl/gb_cpu_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gb_cpu_irq_ctrl_if
// Description : CPU-side bus between the decoder/scheduler and the IRQ control.
// Revision    : 1.0 - initial release
// ============================================================================
interface gb_cpu_irq_ctrl_if #(
    parameter int NUM_IRQ = 5
);
    logic [NUM_IRQ-1:0] reg_IF;
    logic [NUM_IRQ-1:0] reg_IE;
    logic               instr_boundary;
    logic               ei_cmd;
    logic               di_cmd;
    logic               reti_cmd;
    logic               halt_cmd;
    logic               ime_o;
    logic               halted_o;
    logic               halt_bug_o;
    logic               dispatch_busy_o;
    logic [2:0]         dispatch_step_o;
    logic [15:0]        vector_o;
    logic [NUM_IRQ-1:0] irq_ack_o;

    modport master (
        output reg_IF, reg_IE, instr_boundary, ei_cmd, di_cmd, reti_cmd, halt_cmd,
        input  ime_o, halted_o, halt_bug_o, dispatch_busy_o, dispatch_step_o,
               vector_o, irq_ack_o
    );

    modport slave (
        input  reg_IF, reg_IE, instr_boundary, ei_cmd, di_cmd, reti_cmd, halt_cmd,
        output ime_o, halted_o, halt_bug_o, dispatch_busy_o, dispatch_step_o,
               vector_o, irq_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/gb_cpu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gb_cpu_irq_ctrl
// Description : Interrupt master enable, HALT handling and 5-cycle dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_cpu_irq_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  wire                  clk,
    input  wire                  reset_n,
    gb_cpu_irq_ctrl_if.slave     bus
);
    localparam logic [2:0] c_S_D0   = 3'd0;
    localparam logic [2:0] c_S_D1   = 3'd1;
    localparam logic [2:0] c_S_D2   = 3'd2;
    localparam logic [2:0] c_S_D3   = 3'd3;
    localparam logic [2:0] c_S_D4   = 3'd4;
    localparam logic [2:0] c_S_RUN  = 3'd5;
    localparam logic [2:0] c_S_HALT = 3'd6;

    // EI delay: 0 idle, 1 waiting for EI's own boundary, 2 armed for the next one
    localparam logic [1:0] c_EI_IDLE = 2'd0;
    localparam logic [1:0] c_EI_WAIT = 2'd1;
    localparam logic [1:0] c_EI_ARM  = 2'd2;

    logic [2:0]         r_state, w_state_nxt;
    logic               r_ime, w_ime_nxt;
    logic [1:0]         r_ei_cnt, w_ei_cnt_nxt;
    logic               r_halt_bug, w_halt_bug_nxt;
    logic [15:0]        r_vector, w_vector_nxt;
    logic [NUM_IRQ-1:0] r_ack, w_ack_nxt;

    logic [NUM_IRQ-1:0] w_pending;
    logic               w_any;
    logic [2:0]         w_winner;
    logic [NUM_IRQ-1:0] w_onehot;
    logic [15:0]        w_vec;
    logic               w_cmd_en;

    assign w_pending = bus.reg_IF & bus.reg_IE;
    assign w_any     = |w_pending;
    assign w_vec     = VEC_BASE + 16'(32'(w_winner) * VEC_STRIDE);
    assign w_cmd_en  = (r_state == c_S_RUN) || (r_state == c_S_HALT);

    // Descending scan so the lowest set index wins
    always_comb begin
        w_winner = 3'd0;
        w_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_winner    = 3'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ime_nxt      = r_ime;
        w_ei_cnt_nxt   = r_ei_cnt;
        w_halt_bug_nxt = 1'b0;
        w_vector_nxt   = r_vector;
        w_ack_nxt      = r_ack;

        if (w_cmd_en) begin
            if (bus.di_cmd) begin
                w_ime_nxt    = 1'b0;
                w_ei_cnt_nxt = c_EI_IDLE;
            end else begin
                if (bus.ei_cmd) begin
                    w_ei_cnt_nxt = bus.instr_boundary ? c_EI_ARM : c_EI_WAIT;
                end else if (bus.instr_boundary && (r_ei_cnt == c_EI_WAIT)) begin
                    w_ei_cnt_nxt = c_EI_ARM;
                end else if (bus.instr_boundary && (r_ei_cnt == c_EI_ARM)) begin
                    w_ime_nxt    = 1'b1;
                    w_ei_cnt_nxt = c_EI_IDLE;
                end
                if (bus.reti_cmd) begin
                    w_ime_nxt = 1'b1;
                end
            end
        end

        case (r_state)
            c_S_RUN: begin
                if (bus.instr_boundary && r_ime && w_any) begin
                    w_state_nxt  = c_S_D0;
                    w_ime_nxt    = 1'b0;
                    w_ei_cnt_nxt = c_EI_IDLE;
                end else if (bus.halt_cmd) begin
                    if (r_ime || !w_any) w_state_nxt = c_S_HALT;
                    else                 w_halt_bug_nxt = 1'b1;
                end
            end
            c_S_HALT: begin
                if (w_any) begin
                    if (r_ime) begin
                        w_state_nxt  = c_S_D0;
                        w_ime_nxt    = 1'b0;
                        w_ei_cnt_nxt = c_EI_IDLE;
                    end else begin
                        w_state_nxt = c_S_RUN;
                    end
                end
            end
            c_S_D0: w_state_nxt = c_S_D1;
            c_S_D1: w_state_nxt = c_S_D2;
            c_S_D2: begin
                // PC-high is pushed now; a source withdrawn by then yields vector 0
                w_state_nxt  = c_S_D3;
                w_vector_nxt = w_any ? w_vec : 16'h0000;
                w_ack_nxt    = w_any ? w_onehot : '0;
            end
            c_S_D3: w_state_nxt = c_S_D4;
            c_S_D4: w_state_nxt = c_S_RUN;
            default: w_state_nxt = c_S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_S_RUN;
            r_ime      <= 1'b0;
            r_ei_cnt   <= c_EI_IDLE;
            r_halt_bug <= 1'b0;
            r_vector   <= 16'h0000;
            r_ack      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ime      <= w_ime_nxt;
            r_ei_cnt   <= w_ei_cnt_nxt;
            r_halt_bug <= w_halt_bug_nxt;
            r_vector   <= w_vector_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    assign bus.ime_o           = r_ime;
    assign bus.halted_o        = (r_state == c_S_HALT);
    assign bus.halt_bug_o      = r_halt_bug;
    assign bus.dispatch_busy_o = (r_state <= c_S_D4);
    assign bus.dispatch_step_o = (r_state <= c_S_D4) ? r_state : 3'd0;
    assign bus.vector_o        = r_vector;
    assign bus.irq_ack_o       = (r_state == c_S_D3) ? r_ack : '0;

endmodule
`default_nettype wire
